somador_subtrator_serial: RTL and testbench

- N-bit bit-serial adder/subtractor: one 1-bit full adder/subtractor slice, time-multiplexed over the operand bits, LSB first, one bit per clock.
- Successor to the combinational 1-bit cell. Adds operand width N, start/busy/done handshake, registered results, and carry/borrow, overflow and zero flags.
- Intended as a low-area arithmetic unit driven by a simple controller.

---
 rtl/somador_subtrator_serial.sv | 78 +++++++
 tb/tb_somador_subtrator_serial.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/somador_subtrator_serial.sv
// somador_subtrator_serial: bit-serial N-bit adder/subtractor, LSB first, with start/busy/done handshake and flags
module somador_subtrator_serial #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Te,
  input  logic         M,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] S,
  output logic         Ts,
  output logic         V,
  output logic         Z
);
  localparam int CW = $clog2(N);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [N-1:0] a_r, b_r, sh, sh_n;
  logic [CW-1:0] cnt;
  logic m_r, c, bb, s, c_n, last;
  always_comb begin
    bb = b_r[0] ^ m_r;
    s = a_r[0] ^ bb ^ c;
    c_n = (a_r[0] & bb) | (c & (a_r[0] ^ bb));
    sh_n = {s, sh[N-1:1]};
    last = cnt == CW'(N - 1);
    state_n = state == IDLE ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // Subtraction runs as A + ~B + ~Te, so borrow is the inverted final carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      sh   <= '0;
      m_r  <= 1'b0;
      c    <= 1'b0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      S    <= '0;
      Ts   <= 1'b0;
      V    <= 1'b0;
      Z    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        a_r  <= A;
        b_r  <= B;
        m_r  <= M;
        c    <= M ? ~Te : Te;
        cnt  <= '0;
        sh   <= '0;
        busy <= 1'b1;
      end else if (state == RUN) begin
        a_r <= a_r >> 1;
        b_r <= b_r >> 1;
        sh  <= sh_n;
        c   <= c_n;
        cnt <= cnt + 1'b1;
        if (last) begin
          S    <= sh_n;
          Ts   <= m_r ^ c_n;
          V    <= c_n ^ c;
          Z    <= sh_n == '0;
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_somador_subtrator_serial.sv
// tb_somador_subtrator_serial: directed and random checks against an arithmetic reference model
module tb_somador_subtrator_serial;
  localparam int N = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, Te = 1'b0, M = 1'b0;
  logic [N-1:0] A = '0, B = '0, S;
  logic busy, done, Ts, V, Z;
  int vectors = 0, errs = 0;
  int e_s, e_ts, e_v, e_z;

  somador_subtrator_serial #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Te(Te), .M(M),
    .busy(busy), .done(done), .S(S), .Ts(Ts), .V(V), .Z(Z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sgn(input int x);
    return x >= (1 << (N - 1)) ? x - (1 << N) : x;
  endfunction

  function automatic void model(input int a, input int b, input int te, input int m);
    int r, sr;
    r  = m ? a - b - te : a + b + te;
    sr = m ? sgn(a) - sgn(b) - te : sgn(a) + sgn(b) + te;
    e_s  = r & ((1 << N) - 1);
    e_ts = m ? int'(r < 0) : int'(r >= (1 << N));
    e_v  = int'(sr > (1 << (N - 1)) - 1 || sr < -(1 << (N - 1)));
    e_z  = int'(e_s == 0);
  endfunction

  // Drives a request at the current negedge, then scrambles inputs after the accepting edge.
  task automatic issue(input int a, input int b, input int te, input int m);
    A = N'(a); B = N'(b); Te = te[0]; M = m[0]; start = 1'b1;
    model(a, b, te, m);
    @(negedge clk);
    start = 1'b0;
    A = N'($urandom); B = N'($urandom); Te = 1'($urandom); M = 1'($urandom);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < N; i++) begin
      chk({tag, ".busy"}, int'(busy), 1);
      chk({tag, ".nodone"}, int'(done), 0);
      @(negedge clk);
    end
    chk({tag, ".done"}, int'(done), 1);
    chk({tag, ".busy_off"}, int'(busy), 0);
    chk({tag, ".S"}, int'(S), e_s);
    chk({tag, ".Ts"}, int'(Ts), e_ts);
    chk({tag, ".V"}, int'(V), e_v);
    chk({tag, ".Z"}, int'(Z), e_z);
  endtask

  task automatic op(input string tag, input int a, input int b, input int te, input int m);
    @(negedge clk);
    chk({tag, ".done_clr"}, int'(done), 0);
    issue(a, b, te, m);
    wait_done(tag);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.S", int'(S), 0);
    chk("rst.flags", int'({Ts, V, Z}), 0);
    rst = 1'b0;

    op("add_co", 'hFF, 'h01, 0, 0);
    chk("add_co.S_const", int'(S), 'h00);
    chk("add_co.TsVZ_const", int'({Ts, V, Z}), 3'b101);
    op("add_ovf", 'h7F, 'h01, 0, 0);
    chk("add_ovf.S_const", int'(S), 'h80);
    op("add_cin", 'h05, 'h03, 1, 0);
    chk("add_cin.S_const", int'(S), 'h09);
    op("sub_bo", 'h05, 'h07, 0, 1);
    chk("sub_bo.S_const", int'(S), 'hFE);
    op("sub_ovf", 'h80, 'h01, 0, 1);
    chk("sub_ovf.V_const", int'(V), 1);
    op("sub_bin", 'h10, 'h01, 1, 1);
    chk("sub_bin.S_const", int'(S), 'h0E);
    op("sub_zero", 'h01, 'h00, 1, 1);
    chk("sub_zero.Z_const", int'(Z), 1);

    // start held high through RUN with different operands must be ignored
    @(negedge clk);
    issue('h21, 'h10, 0, 0);
    start = 1'b1; A = 'h99; B = 'h77;
    for (int i = 0; i < N - 1; i++) begin
      chk("hold.nodone", int'(done), 0);
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    chk("hold.done", int'(done), 1);
    chk("hold.S", int'(S), 'h31);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold.single", int'(done | busy), 0);
    end

    // back-to-back: request in the done cycle
    @(negedge clk);
    issue('h40, 'h02, 0, 0);
    wait_done("b2b1");
    issue('h40, 'h02, 0, 1);
    wait_done("b2b2");
    chk("b2b2.S_const", int'(S), 'h3E);

    // reset in the fourth RUN cycle
    @(negedge clk);
    issue('hAA, 'h11, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst.busy", int'(busy), 0);
    chk("mrst.done", int'(done), 0);
    chk("mrst.S", int'(S), 0);
    chk("mrst.flags", int'({Ts, V, Z}), 0);
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      chk("mrst.nodone", int'(done), 0);
    end
    op("post_rst", 'h12, 'h34, 0, 0);
    chk("post_rst.S_const", int'(S), 'h46);

    for (int k = 0; k < 40; k++) begin
      if (k % 2) issue(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)), int'($urandom_range(1)));
      else begin
        @(negedge clk);
        issue(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)), int'($urandom_range(1)));
      end
      wait_done("rand");
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
